// File: rtl/axi_ic_pkg.sv
// Shared types for the AXI interconnect write-response path: BRESP codes and the
// buffered B-beat record passed between the arbiter-side router and its FIFO.
package axi_ic_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    // Field widths are fixed upper bounds; routers zero-extend their narrower indices.
    localparam int SLV_IDX_W = 4;
    localparam int MST_ID_W  = 4;

    typedef struct packed {
        logic [SLV_IDX_W-1:0] slv;
        logic [MST_ID_W-1:0]  id;
        axi_resp_t            resp;
    } b_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO of B-beat records. The head entry is presented combinationally
// from registered state; push is ignored when full and pop is ignored when empty.
module resp_fifo
    import axi_ic_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  b_entry_t      din,
    input  logic          pop,
    output b_entry_t      head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    b_entry_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/write_resp_router.sv
// Write-response router: buffers arbitrated B beats, acks the source slave with a
// one-cycle BREADY pulse and presents the FIFO head to the master named by its ID.
module write_resp_router
    import axi_ic_pkg::*;
#(
    parameter int Num_Of_Masters  = 2,
    parameter int Masters_Id_Size = $clog2(Num_Of_Masters),
    parameter int Num_Of_Slaves   = 4,
    parameter int Slaves_Id_Size  = $clog2(Num_Of_Slaves),
    parameter int Fifo_Depth      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Sel_Valid,
    input  logic [Slaves_Id_Size-1:0]       Selected_Slave,
    input  logic [Masters_Id_Size-1:0]      Sel_Resp_ID,
    input  logic [1:0]                      Sel_Write_Resp,
    output logic                            Channel_Granted,
    output logic [Num_Of_Slaves-1:0]        Slave_bready,
    output logic [Num_Of_Masters-1:0]       S_AXI_bvalid,
    output logic [1:0]                      S_AXI_bresp,
    input  logic [Num_Of_Masters-1:0]       S_AXI_bready,
    output logic [$clog2(Fifo_Depth):0]     Occupancy,
    output logic [7:0]                      Err_Count
);

    localparam int CW = $clog2(Fifo_Depth) + 1;
    localparam logic [Masters_Id_Size:0] NUM_M = Num_Of_Masters[Masters_Id_Size:0];

    logic                         accept;
    logic                         bad_id;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic [Masters_Id_Size-1:0]   head_id;
    logic [Num_Of_Slaves-1:0]     ack_onehot;
    b_entry_t                     entry;
    b_entry_t                     head;

    // Handshakes: a beat transfers on any posedge where valid and ready are both high;
    // upstream, ready (Channel_Granted) is !full from registered count only; downstream,
    // BVALID holds with stable BRESP until the addressed master's BREADY is seen.
    assign Channel_Granted = ~full;
    assign accept          = Sel_Valid & Channel_Granted;
    assign bad_id          = ({1'b0, Sel_Resp_ID} >= NUM_M);
    assign push            = accept & ~bad_id;

    always_comb begin
        entry = '0;
        entry.slv[Slaves_Id_Size-1:0]  = Selected_Slave;
        entry.id[Masters_Id_Size-1:0]  = Sel_Resp_ID;
        entry.resp                     = Sel_Write_Resp;
        ack_onehot                     = '0;
        ack_onehot[Selected_Slave]     = 1'b1;
    end

    resp_fifo #(
        .DEPTH (Fifo_Depth),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (Occupancy)
    );

    assign head_id = head.id[Masters_Id_Size-1:0];

    always_comb begin
        S_AXI_bvalid = '0;
        S_AXI_bresp  = RESP_OKAY;
        if (!empty) begin
            S_AXI_bvalid[head_id] = 1'b1;
            S_AXI_bresp           = head.resp;
        end
    end

    assign pop = ~empty & S_AXI_bready[head_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            Slave_bready <= '0;
            Err_Count    <= '0;
        end else begin
            Slave_bready <= accept ? ack_onehot : '0;
            if (accept && bad_id && Err_Count != 8'hFF) Err_Count <= Err_Count + 8'd1;
        end
    end

    // Bad IDs never enter the FIFO, so a stored head always names a real master and slave.
    always_ff @(posedge clk) begin
        if (!rst && !empty)
            assert (32'(head.id) < Num_Of_Masters && 32'(head.slv) < Num_Of_Slaves);
    end

endmodule
